// File: rtl/mux_sel_pipe_if.sv
// mux_sel_pipe_if: input offer and output word handshake bundle for mux_sel_pipe
interface mux_sel_pipe_if #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = (NUM_IN <= 2) ? 1 : $clog2(NUM_IN);
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;
  modport slave (
    input  in_bus, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_err, out_valid
  );
  modport master (
    output in_bus, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_err, out_valid
  );
endinterface

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: N-way registered select mux with valid/ready and a 1-entry skid buffer
module mux_sel_pipe #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4
) (
  input logic            clk,
  input logic            rst_n,
  mux_sel_pipe_if.slave  bus
);
  localparam int SEL_W = (NUM_IN <= 2) ? 1 : $clog2(NUM_IN);
  localparam int W = WIDTH + SEL_W + 1;
  localparam logic [SEL_W:0] NUM_L = (SEL_W + 1)'(NUM_IN);
  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;
  state_t state_q, state_d;
  logic [W-1:0] o_q, o_d, s_q, s_d, nw;
  logic [WIDTH-1:0] word;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, acc, con;
  // resolve the offered select into a tagged word {err, sel, data}; out-of-range selects give zero data
  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_IN; k++)
      word = (bus.in_sel == k[SEL_W-1:0]) ? bus.in_bus[k*WIDTH +: WIDTH] : word;
    nw = {~({1'b0, bus.in_sel} < NUM_L), bus.in_sel, word};
  end
  // occupancy state machine: O is the output register, S catches the word that arrives while O is stalled
  always_comb begin
    acc = bus.in_valid & in_ready_q;
    con = out_valid_q & bus.out_ready;
    state_d = state_q;
    o_d = o_q;
    s_d = s_q;
    case (state_q)
      EMPTY: begin
        o_d = acc ? nw : o_q;
        state_d = acc ? HALF : EMPTY;
      end
      HALF: begin
        o_d = (acc & con) ? nw : o_q;
        s_d = (acc & ~con) ? nw : s_q;
        state_d = (acc & ~con) ? FULL : (~acc & con) ? EMPTY : HALF;
      end
      FULL: begin
        o_d = con ? s_q : o_q;
        state_d = con ? HALF : FULL;
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = state_d != FULL;
    out_valid_d = state_d != EMPTY;
  end
  // all state and every output is a flop; reset discards any buffered words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      o_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_q         <= o_d;
      s_q         <= s_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign bus.out_data  = o_q[WIDTH-1:0];
  assign bus.out_sel   = o_q[WIDTH +: SEL_W];
  assign bus.out_err   = o_q[W-1];
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
endmodule
